// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES encryption sequencer.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_KEY = 3'd1,
    ST_ROUND    = 3'd2,
    ST_FINAL    = 3'd3,
    ST_OUT      = 3'd4
  } seq_state_e;

  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic int round_idx_w(input int nr);
    return $clog2(nr + 1);
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Loadable, saturating round-key index counter; flags the last full round (Nr-1).
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int Nr = 10,
  parameter int RW = round_idx_w(Nr)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  input  logic          inc,
  output logic [RW-1:0] count,
  output logic          term
);

  logic [RW-1:0] count_r;

  // Round index register; never allowed past Nr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {RW{1'b0}};
    end else if (clear) begin
      count_r <= {RW{1'b0}};
    end else if (load) begin
      count_r <= (load_val > RW'(Nr)) ? RW'(Nr) : load_val;
    end else if (inc && (count_r < RW'(Nr))) begin
      count_r <= count_r + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign term  = (count_r == RW'(Nr - 1));

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: owns the round-state register, key index and the
// plaintext/ciphertext handshakes around a shared iterative round datapath.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10,
  parameter int RW = round_idx_w(Nr)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] data_in,
  input  logic                   key_valid,
  output logic                   key_lock,
  output logic [AES_BLOCK_W-1:0] pt_q,
  input  logic [AES_BLOCK_W-1:0] ark0_out,
  output logic [AES_BLOCK_W-1:0] state_q,
  input  logic [AES_BLOCK_W-1:0] round_out,
  input  logic [AES_BLOCK_W-1:0] final_out,
  output logic [RW-1:0]          round_idx,
  output logic                   last_round,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] data_out
);

  if (!((Nk == 4 || Nk == 6 || Nk == 8) && (Nr == nr_for_nk(Nk)) && (RW >= round_idx_w(Nr))))
  begin : g_bad_params
    $error("aes_round_sequencer: illegal Nk/Nr/RW combination");
  end

  seq_state_e             state_r;
  logic [AES_BLOCK_W-1:0] pt_r;
  logic [AES_BLOCK_W-1:0] st_r;
  logic [AES_BLOCK_W-1:0] dout_r;
  logic                   in_ready_r;
  logic                   key_lock_r;
  logic                   busy_r;
  logic                   out_valid_r;
  logic                   last_round_r;
  logic                   cnt_clear_s;
  logic                   cnt_load_s;
  logic                   cnt_inc_s;
  logic                   cnt_term_s;
  logic [RW-1:0]          cnt_s;

  // Round counter control, decoded from the current state.
  always_comb begin
    cnt_clear_s = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE:     cnt_clear_s = 1'b1;
      ST_WAIT_KEY: cnt_load_s  = key_valid;
      ST_ROUND:    cnt_inc_s   = 1'b1;
      ST_FINAL:    cnt_inc_s   = 1'b0;
      ST_OUT:      cnt_clear_s = out_ready;
      default:     cnt_clear_s = 1'b1;
    endcase
  end

  aes_round_counter #(.Nr(Nr), .RW(RW)) u_round_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .load     (cnt_load_s),
    .load_val (RW'(1)),
    .inc      (cnt_inc_s),
    .count    (cnt_s),
    .term     (cnt_term_s)
  );

  // Sequencer FSM with all handshake/status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      pt_r         <= {AES_BLOCK_W{1'b0}};
      st_r         <= {AES_BLOCK_W{1'b0}};
      dout_r       <= {AES_BLOCK_W{1'b0}};
      in_ready_r   <= 1'b1;
      key_lock_r   <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      last_round_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            pt_r       <= data_in;
            in_ready_r <= 1'b0;
            key_lock_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_WAIT_KEY;
          end
        end
        ST_WAIT_KEY: begin
          if (key_valid) begin
            st_r    <= ark0_out;
            state_r <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          st_r <= round_out;
          if (cnt_term_s) begin
            last_round_r <= 1'b1;
            state_r      <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          dout_r      <= final_out;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r  <= 1'b0;
            key_lock_r   <= 1'b0;
            busy_r       <= 1'b0;
            in_ready_r   <= 1'b1;
            last_round_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r  <= 1'b0;
          key_lock_r   <= 1'b0;
          busy_r       <= 1'b0;
          in_ready_r   <= 1'b1;
          last_round_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign key_lock   = key_lock_r;
  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign last_round = last_round_r;
  assign pt_q       = pt_r;
  assign state_q    = st_r;
  assign data_out   = dout_r;
  assign round_idx  = cnt_s;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Sequencer for the iterative AES encryption datapath: one shared round stage (SubBytes, ShiftRows, MixColumns, AddRoundKey), one final stage (no MixColumns) and an initial AddRoundKey.
- Owns the 128-bit round-state register, the round/key index and the I/O handshakes, so the round datapath is reused Nr times per block.
- Sits between the serial front end (SPI shifter) and the combinational round modules and KeyExpansion.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, 10, number of rounds; must equal Nk+6, elaboration error otherwise.
- RW, $clog2(Nr+1), width of round_idx.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  sequencer can accept plaintext.
- data_in  in  128  plaintext block.
- key_valid  in  1  expanded key schedule stable and usable.
- key_lock  out  1  key schedule must not change while high.
- pt_q  out  128  captured plaintext; drives the initial AddRoundKey.
- ark0_out  in  128  initial AddRoundKey result (pt_q XOR round key 0).
- state_q  out  128  round-state register; drives both round stages.
- round_out  in  128  full-round result for state_q using key round_idx.
- final_out  in  128  final-round result for state_q using key Nr.
- round_idx  out  RW  round-key index selected by the datapath (0..Nr).
- last_round  out  1  high when round_idx==Nr.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- data_out  out  128  ciphertext register.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except in_ready=1; pt_q, state_q and data_out are cleared to 0.
- States: IDLE, WAIT_KEY, ROUND, FINAL, OUT.
- IDLE:
  - in_ready=1; round_idx=0.
  - When in_valid is high: pt_q<=data_in, go to WAIT_KEY.
- WAIT_KEY:
  - in_ready=0; key_lock=1.
  - Wait while key_valid is low; there is no timeout.
  - When key_valid is high: state_q<=ark0_out, round_idx<=1, go to ROUND.
- ROUND:
  - Every cycle: state_q<=round_out, round_idx<=round_idx+1.
  - When round_idx==Nr-1 at the edge, go to FINAL (round_idx becomes Nr).
  - Exactly Nr-1 ROUND cycles per block.
- FINAL:
  - data_out<=final_out, out_valid<=1, go to OUT.
  - last_round=1 in this state.
- OUT:
  - out_valid held and data_out stable until out_ready is high.
  - On the handshake edge: out_valid<=0, round_idx<=0, key_lock<=0, go to IDLE.
  - out_ready arriving in the same cycle out_valid first rises completes the transfer in that cycle.
- Latency: with key_valid already high, accept at edge T gives out_valid high after edge T+Nr+1 (11 cycles for AES-128).
- Throughput: one block per Nr+2 cycles (plus at least 1 cycle of OUT). in_ready is low in OUT, so a new block is never accepted before the previous ciphertext is taken.
- key_lock: high from WAIT_KEY entry through the OUT handshake. key_valid is sampled only in WAIT_KEY; dropping it later has no effect.
- state_q is written only in WAIT_KEY (on exit) and in ROUND; it holds in all other states.
- out_ready while out_valid is low is ignored. in_valid outside IDLE is ignored.
- Reset mid-operation: immediate return to the reset values; the in-flight block is discarded and no partial out_valid is produced.
- round_idx never exceeds Nr; any illegal encoded state recovers to IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM state typedef;
  - AES_BLOCK_W=128;
  - the function nr_for_nk(Nk)=Nk+6;
  - the round-index width helper.
- One natural sub-module, aes_round_counter: loadable, saturating round_idx counter with a terminal flag at Nr-1. Everything else stays in this block.

Test Plan:
- FIPS-197 C.1 (Nk=4), real datapath attached, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, key_valid=1, out_ready=1 -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises 11 cycles after accept; round_idx steps 1..10.
- FIPS-197 C.3 (Nk=8, Nr=14), key 000102..1f, same pt -> data_out=8ea2b7ca516745bfeafc49904b496089; latency 15 cycles.
- key_valid held low for 5 cycles after accept -> FSM stays in WAIT_KEY with key_lock=1; latency becomes 16; ciphertext is unchanged from C.1.
- out_ready held low for 7 cycles -> out_valid stays 1, data_out stable, in_ready=0; a second in_valid is ignored; the block is accepted only after the handshake.
- reset asserted while round_idx=5 -> all outputs return to reset values asynchronously; the next C.1 block after release yields the correct ciphertext.
- Back-to-back C.1 blocks with in_valid and out_ready tied high -> two correct outputs; the second accept happens exactly one cycle after the first output handshake.
